// File: rtl/pointer_pool_arbiter.sv
// Round-robin allocation/release arbiter in front of a shared free-pointer pool.
// Tracks pool read latency and reports occupancy, low-watermark and overflow.
module pointer_pool_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int LOW_WM     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            alloc_req,
    output logic [NUM_CH-1:0]            alloc_vld,
    output logic [DATA_WIDTH-1:0]        alloc_ptr,
    input  logic [NUM_CH-1:0]            rel_req,
    input  logic [NUM_CH*DATA_WIDTH-1:0] rel_ptr,
    output logic [NUM_CH-1:0]            rel_ack,
    output logic                         pool_rd_req,
    input  logic [DATA_WIDTH-1:0]        pool_rd_dout,
    output logic                         pool_wr_req,
    output logic [DATA_WIDTH-1:0]        pool_wr_din,
    input  logic                         pool_empty,
    input  logic                         pool_full,
    input  logic [DATA_WIDTH-1:0]        pool_usedw,
    input  logic                         pool_init_done,
    output logic [DATA_WIDTH:0]          free_cnt,
    output logic                         pool_low,
    output logic                         rel_ovf_err
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FW = DATA_WIDTH + 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_run;

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                if (pool_init_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Returns {found, index}; search begins one past the previous winner.
    function automatic logic [CW:0] rr_pick(
        input logic [NUM_CH-1:0] req,
        input logic [CW-1:0]     last
    );
        logic [CW:0] res;
        int          idx;
        res = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_CH;
            if (req[idx]) begin
                res = {1'b1, CW'(idx)};
            end
        end
        return res;
    endfunction

    logic [FW-1:0]         w_avail;
    logic [FW-1:0]         w_unrefl;
    logic [NUM_CH-1:0]     w_elig;
    logic [CW:0]           w_apick;
    logic                  w_agnt;
    logic [CW:0]           w_rpick;
    logic                  w_rsel;
    logic                  w_rdo;
    logic [DATA_WIDTH-1:0] w_rel_ptr_a [NUM_CH];

    logic [NUM_CH-1:0]     r_pend;
    logic [CW-1:0]         r_alast;
    logic [CW-1:0]         r_rlast;
    logic                  r_pv [RD_LATENCY+1];
    logic [CW-1:0]         r_pc [RD_LATENCY+1];
    logic                  r_gnt_d2;
    logic [NUM_CH-1:0]     r_vld;
    logic [DATA_WIDTH-1:0] r_ptr;
    logic [NUM_CH-1:0]     r_ack;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [FW-1:0]         r_free;
    logic                  r_low;
    logic                  r_ovf;

    assign w_avail  = pool_full ? {1'b1, {DATA_WIDTH{1'b0}}}
                                : {1'b0, pool_usedw};
    // Reads granted in the last two cycles may not be in pool_usedw yet.
    assign w_unrefl = FW'(r_pv[0]) + FW'(r_gnt_d2);
    assign w_elig   = alloc_req & ~r_pend;
    assign w_apick  = rr_pick(w_elig, r_alast);
    assign w_agnt   = w_run & w_apick[CW] & ~pool_empty
                    & (w_avail > w_unrefl);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_rel_ptr_a[i] = rel_ptr[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_rpick = rr_pick(rel_req, r_rlast);
    assign w_rsel  = w_run & w_rpick[CW];
    assign w_rdo   = w_rsel & ~pool_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= '0;
            r_alast  <= CW'(NUM_CH - 1);
            r_gnt_d2 <= 1'b0;
            r_vld    <= '0;
            r_ptr    <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                r_pv[k] <= 1'b0;
                r_pc[k] <= '0;
            end
        end else begin
            r_pv[0] <= w_agnt;
            r_pc[0] <= w_apick[CW-1:0];
            for (int k = 1; k <= RD_LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pc[k] <= r_pc[k-1];
            end
            r_gnt_d2 <= r_pv[0];
            r_vld    <= '0;
            if (r_pv[RD_LATENCY]) begin
                r_vld <= NUM_CH'(1) << r_pc[RD_LATENCY];
                r_ptr <= pool_rd_dout;
            end
            if (w_agnt) begin
                r_alast <= w_apick[CW-1:0];
            end
            r_pend <= (r_pend | (w_agnt ? NUM_CH'(1) << w_apick[CW-1:0]
                                        : NUM_CH'(0))) & ~r_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rlast <= CW'(NUM_CH - 1);
            r_ack   <= '0;
            r_wr    <= 1'b0;
            r_din   <= '0;
            r_ovf   <= 1'b0;
            r_free  <= '0;
            r_low   <= 1'b0;
        end else begin
            r_ack <= w_rdo ? NUM_CH'(1) << w_rpick[CW-1:0] : NUM_CH'(0);
            r_wr  <= w_rdo;
            if (w_rdo) begin
                r_din   <= w_rel_ptr_a[w_rpick[CW-1:0]];
                r_rlast <= w_rpick[CW-1:0];
            end
            if (w_rsel && pool_full) begin
                r_ovf <= 1'b1;
            end
            r_free <= w_avail;
            r_low  <= (r_free < FW'(LOW_WM));
        end
    end

    assign alloc_vld   = r_vld;
    assign alloc_ptr   = r_ptr;
    assign pool_rd_req = r_pv[0];
    assign rel_ack     = r_ack;
    assign pool_wr_req = r_wr;
    assign pool_wr_din = r_din;
    assign free_cnt    = r_free;
    assign pool_low    = r_low;
    assign rel_ovf_err = r_ovf;

endmodule

// File: doc/pointer_pool_arbiter.md
Name: pointer_pool_arbiter

Overview:
- Shares the free-pointer pool (a pointer FIFO pre-loaded with 0..2^DATA_WIDTH-1) between NUM_CH buffer channels.
- Allocation side: grants one free pointer per request, round-robin across channels, and sequences the pool's non-showahead read latency.
- Release side: returns freed pointers to the pool, round-robin, one per cycle.
- Sits between the per-queue write/read controllers and the pointer pool. It also reports pool occupancy, low-watermark and error status.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DATA_WIDTH, 10, pointer width. Pool capacity is 2^DATA_WIDTH.
- RD_LATENCY, 2, cycles from pool_rd_req high to valid pool_rd_dout.
- LOW_WM, 8, free-count threshold for pool_low.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_req  in  NUM_CH  per-channel allocation request (level; hold until alloc_vld)
- alloc_vld  out  NUM_CH  one-hot pulse: pointer delivered to that channel
- alloc_ptr  out  DATA_WIDTH  pointer accompanying alloc_vld
- rel_req  in  NUM_CH  per-channel release request (level; hold until rel_ack)
- rel_ptr  in  NUM_CH*DATA_WIDTH  flattened release pointers; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- rel_ack  out  NUM_CH  one-hot pulse: release accepted
- pool_rd_req  out  1  pool read request
- pool_rd_dout  in  DATA_WIDTH  pool read data
- pool_wr_req  out  1  pool write request
- pool_wr_din  out  DATA_WIDTH  pool write data
- pool_empty  in  1  pool empty flag
- pool_full  in  1  pool full flag
- pool_usedw  in  DATA_WIDTH  pool occupancy (wraps to 0 when full)
- pool_init_done  in  1  pool initialisation complete
- free_cnt  out  DATA_WIDTH+1  registered free-pointer count
- pool_low  out  1  free_cnt < LOW_WM
- rel_ovf_err  out  1  sticky: release attempted while pool full

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0. Reset also clears the arbiter state, the pending mask and the in-flight pipeline.
  - Reset mid-operation: in-flight pool reads are discarded and no alloc_vld is emitted for them.
- State machine, INIT -> RUN:
  - INIT: no pool_rd_req, no pool_wr_req, no acks. Leave INIT on the cycle after pool_init_done is sampled high.
  - RUN: normal operation. Only rst returns the block to INIT.
- Free count:
  - avail = pool_full ? 2^DATA_WIDTH : pool_usedw, held in DATA_WIDTH+1 bits.
  - free_cnt <= avail each cycle.
  - pool_low <= (free_cnt < LOW_WM), registered.
- Pending mask: a channel's bit is set when it is granted and cleared when its alloc_vld fires. A pending channel is excluded from allocation arbitration, so each channel has at most one outstanding allocation.
- Allocation:
  - Each cycle in RUN, eligible = alloc_req & ~pending.
  - If eligible != 0 and avail > unreflected, grant the round-robin winner. The search starts at last-grant+1, modulo NUM_CH.
  - unreflected = number of reads issued in the previous 2 cycles (0..2). A read becomes visible in pool_usedw two cycles after grant.
  - On grant in cycle t:
    - pool_rd_req = 1 at t+1 (registered).
    - The granted channel index enters a RD_LATENCY-deep valid/index shift pipeline.
    - alloc_vld[ch] and alloc_ptr are registered from pool_rd_dout at t+2+RD_LATENCY (default t+4).
  - Throughput: one grant per cycle across channels.
  - No pool read is issued while pool_empty is high or avail == 0. Underflow is impossible by construction.
- Release:
  - Each cycle in RUN, pick the round-robin winner among rel_req, using a pointer independent of the allocation arbiter.
  - In cycle t: rel_ack[ch] pulses at t+1, together with pool_wr_req=1 and pool_wr_din=rel_ptr[ch] (all registered).
  - A requester sees its ack at t+1. It must drop or change its request in that cycle, otherwise it is re-arbitrated.
  - If pool_full is high at t: no write and no ack; rel_ovf_err is set (sticky until rst).
- Simultaneous allocation and release in the same cycle: both proceed independently. A release never bypasses the pool to satisfy an allocation.
- Single requester: a channel holding alloc_req receives a new pointer every RD_LATENCY+3 cycles. The pending bit clears at alloc_vld and re-arbitration starts the next cycle.

Test Plan:
- Init gating: NUM_CH=4, DATA_WIDTH=4. alloc_req=4'b1111 from reset; pool_init_done rises at cycle 20 -> no pool_rd_req before cycle 22. The first four alloc_vld go to ch0,1,2,3 on consecutive cycles, with alloc_ptr 0,1,2,3.
- Round-robin fairness: ch1 and ch3 hold alloc_req continuously -> grants alternate 1,3,1,3. No channel gets a second alloc_vld before the other's pending allocation completes.
- Pool exhaustion: allocate all 16 pointers with no releases -> exactly 16 alloc_vld; free_cnt reaches 0; pool_low=1; pool_rd_req is never asserted while pool_empty=1.
- Release path: ch2 releases ptr 5 in cycle t -> rel_ack[2], pool_wr_req and pool_wr_din=5 at t+1. free_cnt increments by 1 two cycles later.
- Full-pool release: release ptr 3 while pool_full=1 (after init) -> no rel_ack, no pool_wr_req; rel_ovf_err=1 and stays 1 until rst.
- Reset mid-flight: assert rst one cycle after a grant -> no alloc_vld ever appears for that grant; all outputs 0; the block waits in INIT for pool_init_done.
